// File: rtl/pc_fetch_stage.sv
//============================================================================
// Module   : pc_fetch_stage
// Desc     : Program-counter fetch stage with valid/ready fetch handshake,
//            one-bubble branch redirect and sticky halt. Optional
//            misaligned-target trap enabled by PC_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef WORD
`define WORD 64
`endif

module pc_fetch_stage #(
    parameter int               WIDTH    = `WORD,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] PC_INC   = WIDTH'(4)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             halt,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pc_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] fetch_count,
    output logic             halted,
    output logic             misalign_err
);

    localparam logic [1:0] c_boot     = 2'd0;
    localparam logic [1:0] c_run      = 2'd1;
    localparam logic [1:0] c_redirect = 2'd2;
    localparam logic [1:0] c_halted   = 2'd3;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_count;
    logic             w_fire;
    logic             w_misalign;
    logic [WIDTH-1:0] w_target_aligned;

    assign out_valid        = (r_state == c_run);
    assign halted           = (r_state == c_halted);
    assign pc_out           = r_pc;
    assign fetch_count      = r_count;
    assign w_fire           = out_valid & out_ready;
    assign w_target_aligned = branch_target & ~WIDTH'(3);

`ifdef PC_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_misalign = branch_taken & (|branch_target[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (r_state != c_halted && w_misalign) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_err = r_misalign;
`else
    assign w_misalign   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Priority: misalign trap > halt > branch > sequential advance.
    // A fire in the same cycle as halt/branch still counts as a fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_boot;
            r_pc    <= RESET_PC;
            r_count <= '0;
        end else begin
            case (r_state)
                c_halted: begin
                    r_state <= c_halted;
                end
                default: begin
                    if (w_fire) begin
                        r_count <= r_count + WIDTH'(1);
                    end
                    if (w_misalign) begin
                        r_pc    <= branch_target;
                        r_state <= c_halted;
                    end else if (halt) begin
                        r_state <= c_halted;
                    end else if (branch_taken) begin
                        r_pc    <= w_target_aligned;
                        r_state <= c_redirect;
                    end else if (r_state == c_run) begin
                        if (w_fire) begin
                            r_pc <= r_pc + PC_INC;
                        end
                    end else begin
                        r_state <= c_run;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: a phase-level model checked every cycle
// plus literal expectations from hand-worked sequences.
`default_nettype none

module tb_pc_fetch_stage;

    localparam int PH_BOOT = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_BUB  = 2;
    localparam int PH_STOP = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        halt;
    logic        out_ready;
    logic [63:0] pc_out;
    logic        out_valid;
    logic [63:0] fetch_count;
    logic        halted;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [63:0] m_pc;
    logic [63:0] m_cnt;
    int          m_ph;
    bit          m_err;

    pc_fetch_stage #(.WIDTH(64), .RESET_PC(64'h0), .PC_INC(64'h4)) dut (
        .clk          (clk),
        .reset        (reset),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt         (halt),
        .out_ready    (out_ready),
        .pc_out       (pc_out),
        .out_valid    (out_valid),
        .fetch_count  (fetch_count),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 64'h0;
        m_cnt = 64'h0;
        m_ph  = PH_BOOT;
        m_err = 1'b0;
    endtask

    // One rising edge worth of the stage's rules, from the current inputs.
    task automatic model_step();
        bit mis;
        if (m_ph == PH_STOP) return;
        if (m_ph == PH_RUN && out_ready) m_cnt = m_cnt + 1;
`ifdef PC_MISALIGN_TRAP_EN
        mis = branch_taken && (branch_target[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (mis) begin
            m_err = 1'b1;
            m_pc  = branch_target;
            m_ph  = PH_STOP;
        end else if (halt) begin
            m_ph = PH_STOP;
        end else if (branch_taken) begin
            m_pc = {branch_target[63:2], 2'b00};
            m_ph = PH_BUB;
        end else if (m_ph == PH_RUN) begin
            if (out_ready) m_pc = m_pc + 4;
        end else begin
            m_ph = PH_RUN;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_out", pc_out, m_pc);
            chk("out_valid", {63'h0, out_valid}, {63'h0, m_ph == PH_RUN});
            chk("fetch_count", fetch_count, m_cnt);
            chk("halted", {63'h0, halted}, {63'h0, m_ph == PH_STOP});
            chk("misalign_err", {63'h0, misalign_err}, {63'h0, m_err});
        end
    end

    task automatic cyc(input logic br, input logic [63:0] tgt, input logic hl, input logic rd);
        branch_taken  = br;
        branch_target = tgt;
        halt          = hl;
        out_ready     = rd;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; branch_taken = 1'b0; branch_target = '0; halt = 1'b0; out_ready = 1'b0;
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_out, 64'h0);
        chk("rst_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_count", fetch_count, 64'h0);
        reset = 1'b0;

        // Boot bubble then sequential fetch 0,4,8
        cyc(0, 0, 0, 1);
        chk("boot_first_pc", pc_out, 64'h0);
        chk("boot_first_valid", {63'h0, out_valid}, 64'h1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("seq_pc8", pc_out, 64'h8);
        chk("seq_cnt2", fetch_count, 64'h2);
        repeat (3) cyc(0, 0, 0, 0);
        chk("stall_pc", pc_out, 64'h8);
        chk("stall_valid", {63'h0, out_valid}, 64'h1);
        chk("stall_cnt", fetch_count, 64'h2);
        cyc(0, 0, 0, 1);
        chk("resume_pc", pc_out, 64'hC);
        chk("resume_cnt", fetch_count, 64'h3);
        cyc(0, 0, 0, 1);
        chk("pc10", pc_out, 64'h10);

        // Branch with concurrent fire
        cyc(1, 64'h400, 0, 1);
        chk("br_bubble_valid", {63'h0, out_valid}, 64'h0);
        chk("br_cnt", fetch_count, 64'h5);
        cyc(0, 0, 0, 0);
        chk("br_target_pc", pc_out, 64'h400);
        chk("br_target_valid", {63'h0, out_valid}, 64'h1);
`ifndef PC_MISALIGN_TRAP_EN
        cyc(1, 64'h402, 0, 0);
        cyc(0, 0, 0, 0);
        chk("mask_pc", pc_out, 64'h400);
`endif

        // Wrap at top of address space
        cyc(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        cyc(0, 0, 0, 0);
        chk("top_pc", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 0, 0, 1);
        chk("wrap_pc", pc_out, 64'h0);
        chk("wrap_cnt", fetch_count, 64'h6);

        // Back-to-back redirects extend the bubble
        cyc(1, 64'h100, 0, 1);
        cyc(1, 64'h200, 0, 1);
        chk("b2b_valid", {63'h0, out_valid}, 64'h0);
        chk("b2b_cnt", fetch_count, 64'h7);
        cyc(0, 0, 0, 0);
        chk("b2b_pc", pc_out, 64'h200);

        // Halt beats branch; fire still counted; pc frozen
        cyc(1, 64'h20, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 64'h300, 1, 1);
        chk("halt_pc", pc_out, 64'h20);
        chk("halt_flag", {63'h0, halted}, 64'h1);
        chk("halt_cnt", fetch_count, 64'h8);
        cyc(1, 64'h500, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 64'h600, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(1, 64'h700, 0, 0);
        chk("halt_hold_pc", pc_out, 64'h20);
        chk("halt_hold_valid", {63'h0, out_valid}, 64'h0);
        chk("halt_hold_cnt", fetch_count, 64'h8);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_pc", pc_out, 64'h0);
        chk("async_halted", {63'h0, halted}, 64'h0);
        chk("async_cnt", fetch_count, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Branch taken in BOOT
        cyc(1, 64'h80, 0, 1);
        chk("boot_br_valid", {63'h0, out_valid}, 64'h0);
        cyc(0, 0, 0, 0);
        chk("boot_br_pc", pc_out, 64'h80);

        // Misaligned target
        cyc(1, 64'h203, 0, 0);
        cyc(0, 0, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_pc", pc_out, 64'h203);
        chk("mis_err", {63'h0, misalign_err}, 64'h1);
        chk("mis_halted", {63'h0, halted}, 64'h1);
`else
        chk("mis_pc", pc_out, 64'h200);
        chk("mis_err", {63'h0, misalign_err}, 64'h0);
        chk("mis_valid", {63'h0, out_valid}, 64'h1);
`endif

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Program-counter fetch stage feeding the next-PC select mux and the instruction-memory address port.
- Holds the architectural PC and advances it by 4 on each accepted fetch. Redirects to a branch target with a one-cycle bubble.
- Presents the fetch address to decode over a valid/ready handshake.
- Upstream of instruction memory and the IF/ID pipeline register; its sequential PC update consumes the branch-select decision.

Parameters:
- WIDTH, `WORD (64): PC, target and counter width.
- RESET_PC, 0: PC value loaded on reset.
- PC_INC, 4: byte increment per accepted fetch.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- branch_taken  input  1  redirect request, sampled each rising edge.
- branch_target  input  WIDTH  redirect address, valid when branch_taken=1.
- halt  input  1  stop fetching; sticky until reset.
- out_ready  input  1  decode can accept the presented PC.
- pc_out  output  WIDTH  current fetch address.
- out_valid  output  1  pc_out is a valid fetch request.
- fetch_count  output  WIDTH  number of accepted fetches (fires).
- halted  output  1  stage is in HALTED.
- misalign_err  output  1  sticky misaligned-target flag; constant 0 unless the feature macro is defined.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: pc_out=RESET_PC, out_valid=0, fetch_count=0, halted=0, misalign_err=0, state=BOOT. Reset asserted mid-operation overrides everything immediately, without waiting for a clock edge.
- States: BOOT, RUN, REDIRECT, HALTED.
- BOOT: out_valid=0 for exactly one cycle after reset deasserts, then RUN. The first valid PC is RESET_PC.
- RUN:
  - out_valid=1.
  - fire = out_valid & out_ready.
  - On fire: pc <= pc + PC_INC, modulo 2^WIDTH (wraps all-ones-minus-3 to 0), and fetch_count++ (wraps).
  - Without fire: pc_out and out_valid are held stable. A valid PC is never withdrawn except by redirect, halt or reset.
- Redirect:
  - branch_taken=1 in RUN: pc <= branch_target with low 2 bits forced to 0, then go to REDIRECT.
  - Branch has priority over increment. If fire coincides with branch_taken, fetch_count still increments but pc takes the target.
- REDIRECT: out_valid=0 for one cycle (bubble), then RUN presenting the target.
  - A branch_taken arriving in REDIRECT overwrites pc with the new target and stays in REDIRECT one more cycle.
- Halt:
  - halt=1 in any non-reset state: next state HALTED, with priority over branch. A fire in the same cycle still counts.
  - In HALTED: out_valid=0, halted=1, pc frozen; branch_taken and out_ready are ignored. Only reset exits.
- branch_taken and halt in BOOT:
  - branch loads pc and goes to REDIRECT.
  - halt goes to HALTED.
- Latency: a fired PC is replaced by its successor on the next edge, giving 1 fetch/cycle sustained with out_ready=1. Redirect costs exactly 1 bubble cycle.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - branch_taken with branch_target[1:0]!=0 in RUN, BOOT or REDIRECT sets misalign_err=1 (sticky until reset).
  - pc loads the unmasked target for debug visibility, and the state goes to HALTED.
  - Misalign has priority over halt, which has priority over branch; all three set HALTED.
- Undefined: low 2 bits are masked silently and misalign_err is tied to 0.

Test Plan:
- Reset with RESET_PC=0, out_ready=1 for 4 cycles after deassert -> 1 cycle out_valid=0, then pc_out 0,4,8,12 on successive cycles; fetch_count=3 after the third fire.
- out_ready=0 for 3 cycles at pc_out=8 -> pc_out stays 8, out_valid stays 1, fetch_count unchanged; out_ready=1 -> next pc_out=12.
- In RUN at pc 0x10, branch_taken=1, target=0x400 (concurrent fire) -> next cycle out_valid=0, then pc_out=0x400, fetch_count +1; target 0x402 without macro -> pc_out=0x400.
- pc at 0xFFFF_FFFF_FFFF_FFFC, fire -> pc_out=0; back-to-back branches to 0x100 then 0x200 during REDIRECT -> bubble extends, pc_out=0x200.
- halt=1 together with branch_taken at pc 0x20 -> halted=1, out_valid=0, pc_out=0x20 held for 5 cycles regardless of inputs; async reset mid-cycle -> pc_out=RESET_PC immediately.
- With PC_MISALIGN_TRAP_EN, branch target 0x203 -> misalign_err=1, halted=1, pc_out=0x203; without the macro -> pc_out=0x200, misalign_err=0.
